// File: rtl/booth_mul_sequencer.sv
// Sequential signed 16x16 radix-2 Booth multiplier for MUL/MULH.
// One shared signed adder performs one add/subtract step per clock.

module booth_mul_sequencer #(
    parameter int L          = 16,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           Start,
    input  logic [L-1:0]   A_in,
    input  logic [L-1:0]   B_in,
    output logic           Busy,
    output logic           Done,
    output logic [2*L-1:0] Product
);
    // state | meaning
    // IDLE  | waiting for Start; Done may pulse here for one cycle after completion
    // RUN   | one Booth step per clock, 16 steps total

    if (L != 16) begin : gen_bad_width
        $error("booth_mul_sequencer: L must be 16 to match the adder, got %0d", L);
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state, state_next;
    logic [L-1:0] m_q, acc_q, q_q;
    logic         qm1_q;
    logic [3:0]   count_q;
    logic         done_q;
    logic [2*L-1:0] product_q;

    logic         step_sub, step_arith, last_step, zero_operand;
    logic [L-1:0] adder_b, sum, partial, acc_next, q_next;
    logic         adder_ovf, adder_cout_unused, acc_msb;

    assign step_sub     = (q_q[0] == 1'b1) && (qm1_q == 1'b0);
    assign step_arith   = q_q[0] ^ qm1_q;
    assign adder_b      = step_sub ? ~m_q : m_q;
    assign last_step    = (count_q == 4'(L - 1));
    assign zero_operand = EARLY_ZERO && ((A_in == '0) || (B_in == '0));

    FullAdderSigned16bit u_adder (
        .A        (acc_q),
        .B        (adder_b),
        .Cin      (step_sub),
        .S        (sum),
        .Cout     (adder_cout_unused),
        .Overflow (adder_ovf)
    );

    // The true sign of Acc +/- M is S[15]^Overflow, so the shift stays exact for M = -32768.
    always_comb begin
        partial  = step_arith ? sum : acc_q;
        acc_msb  = step_arith ? (sum[L-1] ^ adder_ovf) : acc_q[L-1];
        acc_next = {acc_msb, partial[L-1:1]};
        q_next   = {partial[0], q_q[L-1:1]};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Start && !zero_operand) state_next = RUN;
            RUN:  if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state == RUN);
        Done    = done_q;
        Product = product_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (zero_operand) begin
                            product_q <= '0;
                            done_q    <= 1'b1;
                        end else begin
                            m_q     <= A_in;
                            q_q     <= B_in;
                            acc_q   <= '0;
                            qm1_q   <= 1'b0;
                            count_q <= '0;
                        end
                    end
                end
                RUN: begin
                    acc_q   <= acc_next;
                    q_q     <= q_next;
                    qm1_q   <= q_q[0];
                    count_q <= count_q + 4'd1;
                    if (last_step) begin
                        product_q <= {acc_next, q_next};
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// Plain 16-bit two's complement adder with signed overflow flag.
module FullAdderSigned16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout,
    output logic        Overflow
);
    always_comb begin
        {Cout, S} = {1'b0, A} + {1'b0, B} + {16'd0, Cin};
        Overflow  = (A[15] == B[15]) && (S[15] != A[15]);
    end
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Scoreboard bench for booth_mul_sequencer: one instance with EARLY_ZERO=1, one with EARLY_ZERO=0.
module tb_booth_mul_sequencer;
    logic        clk, rst_n, start, start2;
    logic [15:0] a_in, b_in;
    logic        busy, done, busy2, done2;
    logic [31:0] product, product2;

    booth_mul_sequencer #(.L(16), .EARLY_ZERO(1'b1)) dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .A_in(a_in), .B_in(b_in),
        .Busy(busy), .Done(done), .Product(product)
    );

    booth_mul_sequencer #(.L(16), .EARLY_ZERO(1'b0)) dut_full (
        .Clk(clk), .Rst_n(rst_n), .Start(start2), .A_in(a_in), .B_in(b_in),
        .Busy(busy2), .Done(done2), .Product(product2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] prod;
        int          at_edge;
    } exp_t;

    exp_t        exp_q[$], exp2_q[$];
    exp_t        e_new, e_mon;
    int          n_checks = 0, n_fail = 0;
    int          ecount = 0;
    int          free_at = 0, free2_at = 0;
    int          busy_last = -1, busy2_last = -1;
    logic [31:0] last_product = '0, last_product2 = '0;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return 32'(sa * sb);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Reference model: decides acceptance and completion time from the bench's own stimulus.
    always @(posedge clk) begin
        ecount++;
        if (rst_n && start && ecount >= free_at) begin
            e_new.prod = ref_mul(a_in, b_in);
            if (a_in == 16'd0 || b_in == 16'd0) begin
                e_new.at_edge = ecount;
                free_at       = ecount + 1;
            end else begin
                e_new.at_edge = ecount + 16;
                free_at       = ecount + 17;
                busy_last     = ecount + 15;
            end
            exp_q.push_back(e_new);
        end
        if (rst_n && start2 && ecount >= free2_at) begin
            e_new.prod    = ref_mul(a_in, b_in);
            e_new.at_edge = ecount + 16;
            free2_at      = ecount + 17;
            busy2_last    = ecount + 15;
            exp2_q.push_back(e_new);
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done at %0t: got Done=1 product %h, expected no completion", $time, product);
            end else begin
                e_mon = exp_q.pop_front();
                check("product", product, e_mon.prod);
                check("done_edge", 32'(ecount), 32'(e_mon.at_edge));
                last_product = e_mon.prod;
            end
        end
        check("product_hold", product, last_product);
        check("busy", 32'(busy), 32'(ecount <= busy_last));
        if (done2) begin
            if (exp2_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done_full at %0t: got Done=1 product %h, expected no completion", $time, product2);
            end else begin
                e_mon = exp2_q.pop_front();
                check("product_full", product2, e_mon.prod);
                check("done_edge_full", 32'(ecount), 32'(e_mon.at_edge));
                last_product2 = e_mon.prod;
            end
        end
        check("product_hold_full", product2, last_product2);
        check("busy_full", 32'(busy2), 32'(ecount <= busy2_last));
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp2_q.delete();
        free_at = 0;
        free2_at = 0;
        busy_last = -1;
        busy2_last = -1;
        last_product = '0;
        last_product2 = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_busy_full", 32'(busy2), 32'd0);
        check("rst_product_full", product2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit on_full);
        @(negedge clk);
        a_in = a;
        b_in = b;
        if (on_full) start2 = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0 || ecount <= busy_last || ecount <= busy2_last) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d results pending, expected 0", name, exp_q.size() + exp2_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    logic [15:0] dir_a[5] = '{16'd3, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000};
    logic [15:0] dir_b[5] = '{16'd5, 16'h0001, 16'h8000, 16'h8000, 16'hFFFF};

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        a_in   = '0;
        b_in   = '0;
        #1;
        apply_reset();

        for (int i = 0; i < 5; i++) begin
            issue(dir_a[i], dir_b[i], 1'b0);
            wait_idle("directed");
        end
        issue(16'h8000, 16'h8000, 1'b1);
        wait_idle("directed_full");

        // Start held high; operands churn every cycle, only accepted pairs matter.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 6 * 17 + 3; i++) begin
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle("back_to_back");

        issue(16'h1234, 16'h5678, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        apply_reset();
        issue(16'd2, 16'd3, 1'b0);
        wait_idle("after_reset");

        issue(16'h0000, 16'h8000, 1'b0);
        wait_idle("early_zero_a");
        issue(16'h1234, 16'h0000, 1'b0);
        wait_idle("early_zero_b");
        issue(16'h0000, 16'h8000, 1'b1);
        wait_idle("zero_full");

        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            issue(ra, rb, 1'(i % 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            wait_idle("random");
        end

        wait_idle("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
